// File: rtl/ccff_bitstream_loader_if.sv
// Byte stream into the loader and readback byte stream out of it.
interface ccff_bitstream_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] m_data;
  logic       m_valid;

  modport master (
    output s_data, s_valid,
    input  s_ready, m_data, m_valid
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, m_data, m_valid
  );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// Serializes bitstream bytes MSB-first into the configuration chain and
// reassembles the bits leaving the chain tail into readback bytes.
module ccff_bitstream_loader #(
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                    prog_clk,
  input  logic                    prog_rst_n,
  input  logic                    start,
  input  logic                    abort,
  ccff_bitstream_loader_if.slave  stream,
  output logic                    ccff_head,
  output logic                    ccff_en,
  input  logic                    ccff_tail,
  output logic                    busy,
  output logic                    done
);
  localparam int unsigned NumBytes = (CHAIN_LEN + 7) / 8;
  localparam int unsigned Rem      = CHAIN_LEN % 8;
  localparam int unsigned PadBits  = (Rem == 0) ? 0 : 8 - Rem;
  localparam logic [CNT_W-1:0] ChainLenW = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] NumBytesW = CNT_W'(NumBytes);

  typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] bytes_q, bytes_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic [7:0]       sh_q, sh_d;
  logic [3:0]       sh_cnt_q, sh_cnt_d;
  logic [7:0]       tail_q, tail_d;
  logic [2:0]       tail_cnt_q, tail_cnt_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             head_q, head_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic [7:0]       tail_next;
  logic             s_ready;

  assign tail_next = {tail_q[6:0], ccff_tail};
  assign s_ready   = (state_q == StLoad) && !hold_vld_q && (bytes_q < NumBytesW);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bytes_d    = bytes_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    sh_d       = sh_q;
    sh_cnt_d   = sh_cnt_q;
    tail_d     = tail_q;
    tail_cnt_d = tail_cnt_q;
    m_data_d   = m_data_q;
    m_valid_d  = 1'b0;
    head_d     = head_q;
    en_d       = 1'b0;
    done_d     = done_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StLoad;
          cnt_d      = '0;
          bytes_d    = '0;
          hold_vld_d = 1'b0;
          sh_cnt_d   = '0;
          tail_cnt_d = '0;
          done_d     = 1'b0;
        end
      end
      StLoad: begin
        if (abort) begin
          state_d    = StIdle;
          hold_vld_d = 1'b0;
          sh_cnt_d   = '0;
          tail_cnt_d = '0;
        end else begin
          // The fabric shifted on the previous enable edge; collect its tail bit.
          if (en_q) begin
            tail_d     = tail_next;
            tail_cnt_d = tail_cnt_q + 3'd1;
            if (tail_cnt_q == 3'd7) begin
              m_data_d  = tail_next;
              m_valid_d = 1'b1;
            end
          end
          if (cnt_q == ChainLenW) begin
            state_d = StDone;
            done_d  = 1'b1;
            if (Rem != 0) begin
              m_data_d  = tail_next << PadBits;
              m_valid_d = 1'b1;
            end
          end else begin
            if (sh_cnt_q != 4'd0) begin
              head_d   = sh_q[7];
              en_d     = 1'b1;
              cnt_d    = cnt_q + 1'b1;
              sh_d     = {sh_q[6:0], 1'b0};
              sh_cnt_d = sh_cnt_q - 4'd1;
            end
            // Refill in the same cycle the last bit leaves to keep 1 bit/cycle.
            if (sh_cnt_d == 4'd0 && hold_vld_q) begin
              sh_d       = hold_q;
              sh_cnt_d   = 4'd8;
              hold_vld_d = 1'b0;
            end
            if (s_ready && stream.s_valid) begin
              hold_d     = stream.s_data;
              hold_vld_d = 1'b1;
              bytes_d    = bytes_q + 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bytes_q    <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      sh_q       <= '0;
      sh_cnt_q   <= '0;
      tail_q     <= '0;
      tail_cnt_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      head_q     <= 1'b0;
      en_q       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bytes_q    <= bytes_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      sh_q       <= sh_d;
      sh_cnt_q   <= sh_cnt_d;
      tail_q     <= tail_d;
      tail_cnt_q <= tail_cnt_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      head_q     <= head_d;
      en_q       <= en_d;
      done_q     <= done_d;
    end
  end

  assign stream.s_ready = s_ready;
  assign stream.m_data  = m_data_q;
  assign stream.m_valid = m_valid_q;
  assign ccff_head      = head_q;
  assign ccff_en        = en_q;
  assign busy           = (state_q == StLoad);
  assign done           = done_q;
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Random bitstream loads into a behavioural shift-chain fabric; checks chain
// contents, enable count, byte acceptance and readback of the previous contents.
module tb_ccff_bitstream_loader;
  localparam int L  = 20;
  localparam int NB = (L + 7) / 8;

  logic prog_clk = 1'b0;
  logic prog_rst_n, start, abort, ccff_tail;
  logic ccff_head, ccff_en, busy, done;

  ccff_bitstream_loader_if sif ();

  ccff_bitstream_loader #(
    .CHAIN_LEN (L),
    .CNT_W     (16)
  ) dut (
    .prog_clk   (prog_clk),
    .prog_rst_n (prog_rst_n),
    .start      (start),
    .abort      (abort),
    .stream     (sif.slave),
    .ccff_head  (ccff_head),
    .ccff_en    (ccff_en),
    .ccff_tail  (ccff_tail),
    .busy       (busy),
    .done       (done)
  );

  always #5 prog_clk = ~prog_clk;

  // Fabric model: fab[0] sits next to the head, fab[L-1] drives the tail.
  logic [L-1:0] fab, fab_seed;
  logic         fab_load;
  assign ccff_tail = fab[L-1];
  always @(posedge prog_clk) begin
    if (fab_load) fab <= fab_seed;
    else if (ccff_en) fab <= {fab[L-2:0], ccff_head};
  end

  // Monotone activity counters; tasks work on deltas.
  int unsigned en_cnt = 0, en_rises = 0, acc_cnt = 0;
  logic        en_prev = 1'b0;
  logic [7:0]  rb_q[$];
  always @(negedge prog_clk) begin
    if (ccff_en) en_cnt++;
    if (ccff_en && !en_prev) en_rises++;
    en_prev = ccff_en;
    if (sif.s_valid && sif.s_ready) acc_cnt++;
    if (sif.m_valid) rb_q.push_back(sif.m_data);
  end

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Readback byte k of a chain whose contents were p before the load.
  function automatic logic [7:0] exp_rb(input logic [L-1:0] p, input int k);
    logic [7:0] b;
    b = '0;
    for (int j = 0; j < 8; j++) if (8 * k + j < L) b[7 - j] = p[L - 1 - (8 * k + j)];
    return b;
  endfunction

  task automatic pulse_start();
    @(posedge prog_clk); #1 start = 1'b1;
    @(posedge prog_clk); #1 start = 1'b0;
  endtask

  task automatic run_load(input int gap_max, input bit poke_start, input bit extra);
    logic [L-1:0] prev, expf;
    logic [7:0]   bytes[NB];
    int unsigned  eb, er, ea;
    int           rb, g;
    bit           ok;
    prev = fab;
    for (int i = 0; i < NB; i++) bytes[i] = 8'($urandom);
    for (int i = 0; i < L; i++) expf[L - 1 - i] = bytes[i / 8][7 - (i % 8)];
    eb = en_cnt; er = en_rises; ea = acc_cnt; rb = rb_q.size();
    pulse_start();
    for (int i = 0; i < NB; i++) begin
      sif.s_valid = 1'b1;
      sif.s_data  = bytes[i];
      ok = 1'b0;
      for (int c = 0; c < 100 && !ok; c++) begin
        @(negedge prog_clk);
        ok = sif.s_ready;
      end
      if (!ok) begin
        check_eq("accept_timeout", 32'(ok), 32'd1);
        sif.s_valid = 1'b0;
        return;
      end
      @(posedge prog_clk); #1;
      g = $urandom_range(0, gap_max);
      if (i == NB - 1) begin
        sif.s_valid = extra;
        sif.s_data  = 8'($urandom);
      end else if (g > 0 || poke_start) begin
        sif.s_valid = 1'b0;
      end
      if (poke_start && i == 0) begin
        start = 1'b1;
        @(posedge prog_clk); #1 start = 1'b0;
      end
      if (i != NB - 1) repeat (g) begin @(posedge prog_clk); #1; end
    end
    ok = 1'b0;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge prog_clk);
      ok = done;
    end
    check_eq("done", 32'(done), 32'd1);
    check_eq("busy_after", 32'(busy), 32'd0);
    check_eq("ready_after", 32'(sif.s_ready), 32'd0);
    @(negedge prog_clk);
    sif.s_valid = 1'b0;
    check_eq("en_cycles", 32'(en_cnt - eb), 32'(L));
    check_eq("accepted", 32'(acc_cnt - ea), 32'(NB));
    if (gap_max == 0 && !poke_start) check_eq("contiguous", 32'(en_rises - er), 32'd1);
    check_eq("chain", 32'(fab), 32'(expf));
    check_eq("rb_count", 32'(rb_q.size() - rb), 32'(NB));
    for (int k = 0; k < NB && rb + k < rb_q.size(); k++)
      check_eq($sformatf("rb%0d", k), 32'(rb_q[rb + k]), 32'(exp_rb(prev, k)));
  endtask

  task automatic wait_bits(input int unsigned eb, input int unsigned n);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge prog_clk);
      ok = (en_cnt - eb >= n);
    end
    if (!ok) check_eq("bits_timeout", 32'(ok), 32'd1);
  endtask

  task automatic run_abort();
    int unsigned eb;
    eb = en_cnt;
    pulse_start();
    sif.s_valid = 1'b1;
    sif.s_data  = 8'($urandom);
    wait_bits(eb, 5);
    @(posedge prog_clk); #1 abort = 1'b1; sif.s_valid = 1'b0;
    @(posedge prog_clk); #1 abort = 1'b0;
    @(negedge prog_clk);
    check_eq("abort_en", 32'(ccff_en), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
  endtask

  task automatic run_rst();
    int unsigned eb;
    eb = en_cnt;
    pulse_start();
    sif.s_valid = 1'b1;
    sif.s_data  = 8'($urandom);
    wait_bits(eb, 3);
    #2 prog_rst_n = 1'b0;
    #1;
    check_eq("async_rst", 32'({sif.s_ready, ccff_head, ccff_en, sif.m_data, sif.m_valid,
                               busy, done}), 32'd0);
    sif.s_valid = 1'b0;
    @(posedge prog_clk); #1 prog_rst_n = 1'b1;
  endtask

  initial begin
    prog_rst_n  = 1'b0;
    start       = 1'b0;
    abort       = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data  = '0;
    fab_seed    = L'($urandom);
    fab_load    = 1'b1;
    repeat (3) @(posedge prog_clk);
    #1;
    check_eq("rst_s_ready", 32'(sif.s_ready), 32'd0);
    check_eq("rst_head", 32'(ccff_head), 32'd0);
    check_eq("rst_en", 32'(ccff_en), 32'd0);
    check_eq("rst_m_data", 32'(sif.m_data), 32'd0);
    check_eq("rst_m_valid", 32'(sif.m_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    fab_load   = 1'b0;
    prog_rst_n = 1'b1;

    run_load(0, 1'b0, 1'b1);
    run_load(5, 1'b0, 1'b0);
    run_load(3, 1'b1, 1'b0);
    run_abort();
    run_load(0, 1'b0, 1'b0);
    run_rst();
    for (int n = 0; n < 4; n++) run_load($urandom_range(0, 4), 1'b0, 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
